// File: rtl/ball_pkg.sv
// Shared types and helpers for the ball/paddle/brick draw controllers.
// Holds the controller state encoding, bus widths and the edge-clamped position step.
package ball_pkg;

    localparam int COL_W = 3;
    localparam int POS_W = 10;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ERASE,
        ST_MOVE,
        ST_DRAW
    } state_t;

    // One-pixel step toward 'up'/down, pinned at 0 and at hi; never wraps.
    function automatic logic [POS_W-1:0] step_clamp(input logic [POS_W-1:0] p,
                                                    input logic             up,
                                                    input logic [POS_W-1:0] hi);
        if (up)
            return (p >= hi) ? hi : p + POS_W'(1);
        else
            return (p == '0) ? '0 : p - POS_W'(1);
    endfunction

endpackage

// File: rtl/ball_move_ctrl_sq_scan.sv
// Square scan counter: dx runs 0..SIZE-1 inside dy 0..SIZE-1.
// It moves one position per step and flags the final pixel.
module sq_scan #(
    parameter int SIZE = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       step,
    output logic [3:0] dx,
    output logic [3:0] dy,
    output logic       last
);

    localparam logic [3:0] LAST = 4'(SIZE - 1);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dx <= '0;
            dy <= '0;
        end else if (start) begin
            dx <= '0;
            dy <= '0;
        end else if (step) begin
            if (dx == LAST) begin
                dx <= '0;
                dy <= (dy == LAST) ? '0 : dy + 4'd1;
            end else begin
                dx <= dx + 4'd1;
            end
        end
    end

    assign last = (dx == LAST) && (dy == LAST);

endmodule

// File: rtl/ball_move_ctrl.sv
// One-ball-per-frame sequencer: erase the old square, step x/y, redraw.
// Pixels leave through a valid/ready plot port.
module ball_move_ctrl
    import ball_pkg::*;
#(
    parameter int               MAX_X     = 160,
    parameter int               MAX_Y     = 120,
    parameter int               SIZE      = 4,
    parameter int               START_X   = 78,
    parameter int               START_Y   = 58,
    parameter int               FRAME_DIV = 1,
    parameter logic [COL_W-1:0] BALL_COL  = 3'b111,
    parameter logic [COL_W-1:0] BG_COL    = 3'b000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_tick,
    input  logic             enable,
    input  logic             x_dir,
    input  logic             y_dir,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic [POS_W-1:0] plot_x,
    output logic [POS_W-1:0] plot_y,
    output logic [COL_W-1:0] plot_colour,
    output logic             plot_valid,
    input  logic             plot_ready,
    output logic             busy,
    output logic             moved,
    output logic             overrun
);

    localparam logic [POS_W-1:0] X_HI     = POS_W'(MAX_X - SIZE);
    localparam logic [POS_W-1:0] Y_HI     = POS_W'(MAX_Y - SIZE);
    localparam logic [7:0]       DIV_LAST = 8'(FRAME_DIV - 1);

    state_t     state, next_state;
    logic [7:0] div;
    logic [3:0] dx, dy;
    logic       scan_start, scan_step, scan_last;
    logic       tick_ok;

    sq_scan #(.SIZE(SIZE)) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .start  (scan_start),
        .step   (scan_step),
        .dx     (dx),
        .dy     (dy),
        .last   (scan_last)
    );

    assign tick_ok   = (state == ST_IDLE) && frame_tick && enable;
    assign scan_step = plot_valid && plot_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_INIT;
        else         state <= next_state;
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        next_state = state;
        scan_start = 1'b0;
        case (state)
            ST_INIT: begin
                scan_start = 1'b1;
                next_state = ST_DRAW;
            end
            ST_IDLE: begin
                if (tick_ok && div == DIV_LAST) begin
                    scan_start = 1'b1;
                    next_state = ST_ERASE;
                end
            end
            ST_ERASE: if (scan_step && scan_last) next_state = ST_MOVE;
            ST_MOVE: begin
                scan_start = 1'b1;
                next_state = ST_DRAW;
            end
            ST_DRAW:  if (scan_step && scan_last) next_state = ST_IDLE;
            default:  next_state = ST_INIT;
        endcase
    end

    // Frame divider only counts ticks that could have started a move.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      div <= '0;
        else if (tick_ok) div <= (div == DIV_LAST) ? '0 : div + 8'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x     <= POS_W'(START_X);
            y     <= POS_W'(START_Y);
            moved <= 1'b0;
        end else begin
            moved <= (state == ST_MOVE);
            if (state == ST_MOVE) begin
                x <= step_clamp(x, x_dir, X_HI);
                y <= step_clamp(y, y_dir, Y_HI);
            end
        end
    end

    // Decoded from state so an async reset drops plot_valid without waiting for a clock.
    assign plot_valid  = (state == ST_ERASE) || (state == ST_DRAW);
    assign plot_x      = x + POS_W'(dx);
    assign plot_y      = y + POS_W'(dy);
    assign plot_colour = (state == ST_DRAW) ? BALL_COL : BG_COL;
    assign busy        = (state != ST_IDLE);
    assign overrun     = frame_tick && busy;

endmodule
